mac_port_monitor: RTL and testbench

- Downstream consumer of the MAC accumulator's two 8-bit result ports (port_A / port_B).
- Detects each update on either port and queues a change record in an internal FIFO.
- Drains records over a valid/ready stream to a logger or bus bridge.
- Provides enable/drain control and overflow accounting.

---
 rtl/mac_mon_pkg.sv | 13 +
 rtl/mon_sync_fifo.sv | 67 ++++++
 rtl/mac_port_monitor.sv | 135 +++++++++++++
 tb/tb_mac_port_monitor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mac_mon_pkg.sv
// Shared types and constants for the MAC port monitor.
// Pure declarations: no latency, no flow control.
package mac_mon_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] SRC_A = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;
    localparam int         TS_W  = 16;
endpackage

// File: rtl/mon_sync_fifo.sv
// Synchronous FIFO with registered head data; a push into an empty FIFO is visible after one edge.
// Push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module mon_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_dat_q, rd_dat_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (!do_push && do_pop)
            count_d = count_q - CW'(1);
        // The new head is the entry being written only when the FIFO drains to it this cycle.
        if (do_push && (wr_ptr_q == rd_ptr_d))
            rd_dat_d = push_dat;
        else if (count_d != '0)
            rd_dat_d = mem_q[rd_ptr_d];
        else
            rd_dat_d = rd_dat_q;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_dat;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_dat_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;
    assign count  = count_q;
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
endmodule

// File: rtl/mac_port_monitor.sv
// Queues a change record per update of MAC port_A/port_B; record visible one edge after the change.
// Valid/ready drain; events arriving while full with no pop are dropped and counted. Option: MAC_PORT_MONITOR_TIMESTAMP_EN.
module mac_port_monitor
    import mac_mon_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DW-1:0]          port_a_in,
    input  logic [DW-1:0]          port_b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_src,
    output logic [DW-1:0]          out_a,
    output logic [DW-1:0]          out_b,
`ifdef MAC_PORT_MONITOR_TIMESTAMP_EN
    output logic [TS_W-1:0]        out_ts,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    output logic                   busy
);
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef MAC_PORT_MONITOR_TIMESTAMP_EN
    localparam int EW = 2 + 2*DW + TS_W;
`else
    localparam int EW = 2 + 2*DW;
`endif

    state_t        state_q, state_d;
    logic          busy_q;
    logic [DW-1:0] prev_a_q, prev_a_d;
    logic [DW-1:0] prev_b_q, prev_b_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          chg_a, chg_b, ev, pop, empty;
    logic [1:0]    src;
    logic [EW-1:0] push_dat, rd_dat;
    logic [CW-1:0] fifo_count;
`ifdef MAC_PORT_MONITOR_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
`endif

    always_comb begin
        chg_a    = (port_a_in != prev_a_q);
        chg_b    = (port_b_in != prev_b_q);
        src      = (chg_a ? SRC_A : 2'b00) | (chg_b ? SRC_B : 2'b00);
        ev       = (chg_a || chg_b) && (state_q == RUN);
        pop      = !empty && out_ready;
        prev_a_d = port_a_in;
        prev_b_d = port_b_in;
`ifdef MAC_PORT_MONITOR_TIMESTAMP_EN
        ts_d     = ts_q + TS_W'(1);
        push_dat = {src, port_a_in, port_b_in, ts_q};
`else
        push_dat = {src, port_a_in, port_b_in};
`endif
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (ev && full && !pop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF)
                drop_cnt_d = drop_cnt_q + 8'd1;
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en)
                    state_d = RUN;
                else if ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            prev_a_q   <= '0;
            prev_b_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
`ifdef MAC_PORT_MONITOR_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != IDLE);
            prev_a_q   <= prev_a_d;
            prev_b_q   <= prev_b_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef MAC_PORT_MONITOR_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    mon_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ev),
        .push_dat (push_dat),
        .pop      (pop),
        .rd_dat   (rd_dat),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    assign out_valid = !empty;
    assign out_src   = rd_dat[EW-1 -: 2];
    assign out_a     = rd_dat[EW-3 -: DW];
    assign out_b     = rd_dat[EW-3-DW -: DW];
`ifdef MAC_PORT_MONITOR_TIMESTAMP_EN
    assign out_ts    = rd_dat[TS_W-1:0];
`endif
    assign count     = fifo_count;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mac_port_monitor.sv
// Directed bench for mac_port_monitor: capture, simultaneous change, overflow, drain FSM, reset.
module tb_mac_port_monitor;
    import mac_mon_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] port_a_in = 8'd0;
    logic [7:0] port_b_in = 8'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [1:0] out_src;
    logic [7:0] out_a, out_b;
    logic [3:0] count;
    logic       full, overflow, busy;
    logic [7:0] drop_cnt;
`ifdef MAC_PORT_MONITOR_TIMESTAMP_EN
    logic [15:0] out_ts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac_port_monitor #(.DEPTH(8), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .port_a_in (port_a_in),
        .port_b_in (port_b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .out_a     (out_a),
        .out_b     (out_b),
`ifdef MAC_PORT_MONITOR_TIMESTAMP_EN
        .out_ts    (out_ts),
`endif
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_out", {8'd0, 6'd0, out_src, out_a, out_b}, 32'd0);

        // Basic capture: 0 -> 5 -> 5 -> 20
        rst = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_empty", 32'(out_valid), 32'd0);
        port_a_in = 8'd5;
        tick();
        chk("r1_valid", 32'(out_valid), 32'd1);
        chk("r1_rec", {14'd0, out_src, out_a, out_b}, {14'd0, 2'b01, 8'd5, 8'd0});
        tick();
        chk("r1_popped", 32'(out_valid), 32'd0);
        chk("nochg_count", 32'(count), 32'd0);
        port_a_in = 8'd20;
        tick();
        chk("r2_valid", 32'(out_valid), 32'd1);
        chk("r2_rec", {14'd0, out_src, out_a, out_b}, {14'd0, 2'b01, 8'd20, 8'd0});
        tick();
        chk("r2_popped", 32'(count), 32'd0);

        // Simultaneous A and B change
        out_ready = 1'b0;
        port_a_in = 8'd7;
        port_b_in = 8'd9;
        tick();
        chk("ab_rec", {14'd0, out_src, out_a, out_b}, {14'd0, 2'b11, 8'd7, 8'd9});
        chk("ab_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("ab_popped", 32'(count), 32'd0);

        // Overflow: 10 changes into 8 entries
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            port_a_in = 8'(30 + i);
            tick();
        end
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_head", 32'(out_a), 32'd30);

        // Full with pop and push in the same cycle
        out_ready = 1'b1;
        port_a_in = 8'd50;
        tick();
        chk("fpp_count", 32'(count), 32'd8);
        chk("fpp_drop", 32'(drop_cnt), 32'd2);
        for (int k = 1; k < 8; k++) begin
            chk("drain_order", 32'(out_a), 32'(30 + k));
            tick();
        end
        chk("drain_last", 32'(out_a), 32'd50);
        chk("drain_last_vld", 32'(out_valid), 32'd1);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // DRAIN state: no capture after en falls
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            port_a_in = 8'(60 + i);
            tick();
        end
        chk("dr_count3", 32'(count), 32'd3);
        en = 1'b0;
        tick();
        port_a_in = 8'd70;
        tick();
        port_b_in = 8'd71;
        tick();
        chk("dr_nocap", 32'(count), 32'd3);
        chk("dr_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("dr_pop1", 32'(out_a), 32'd61);
        tick();
        chk("dr_pop2_busy", 32'(busy), 32'd1);
        chk("dr_pop2_cnt", 32'(count), 32'd1);
        tick();
        chk("dr_idle_busy", 32'(busy), 32'd0);
        chk("dr_idle_vld", 32'(out_valid), 32'd0);

        // Reset with 5 records queued
        en = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("reen_nostale", 32'(count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            port_a_in = 8'(80 + i);
            tick();
        end
        chk("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b1;
        tick();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);

        // First record after reset; counter is 0 after the reset edge, 1 at the capture edge
        rst = 1'b0;
        tick();
        port_a_in = 8'd90;
        tick();
        chk("post_rst_rec", {14'd0, out_src, out_a, out_b}, {14'd0, 2'b01, 8'd90, 8'd71});
`ifdef MAC_PORT_MONITOR_TIMESTAMP_EN
        chk("post_rst_ts", 32'(out_ts), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
